// File: rtl/pingpong_bank_ctrl.sv
// Two-bank line-buffer scheduler: capture fills 8-line banks, coder drains 8x8 blocks in raster order.
// Optional PINGPONG_STATS_EN adds drop_cnt / frame_cnt outputs.
module pingpong_bank_ctrl #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720,
  parameter int BX_W   = $clog2(WIDTH/8),
  parameter int BY_W   = $clog2(HEIGHT/8)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_start,
  input  logic            line_done,
  output logic            wr_bank,
  output logic            wr_ready,
  output logic            overflow,
  output logic            rd_valid,
  input  logic            rd_ready,
  input  logic            block_done,
  output logic            rd_bank,
  output logic [BX_W-1:0] rd_block_x,
  output logic [BY_W-1:0] rd_block_y,
`ifdef PINGPONG_STATS_EN
  output logic [15:0]     drop_cnt,
  output logic [15:0]     frame_cnt,
`endif
  output logic            rd_last
);

  localparam logic [BX_W-1:0] LAST_X = BX_W'(WIDTH/8 - 1);
  localparam logic [BY_W-1:0] LAST_Y = BY_W'(HEIGHT/8 - 1);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_t;
  typedef enum logic [1:0] {R_IDLE, R_OFFER, R_BUSY} rstate_t;

  bank_t           bst_q [2];
  bank_t           bst_d [2];
  logic [BY_W-1:0] tag_q [2];
  logic [BY_W-1:0] tag_d [2];
  logic [2:0]      line_q, line_d;
  logic [BY_W-1:0] row_q, row_d;
  logic            wrb_q, wrb_d;
  logic            rdb_q, rdb_d;
  logic [BX_W-1:0] bx_q, bx_d;
  logic            ovf_q, ovf_d;
  rstate_t         rs_q, rs_d;

  assign wr_bank    = wrb_q;
  assign wr_ready   = (bst_q[wrb_q] == B_EMPTY) || (bst_q[wrb_q] == B_FILLING);
  assign overflow   = ovf_q;
  assign rd_valid   = (rs_q == R_OFFER);
  assign rd_bank    = rdb_q;
  assign rd_block_x = bx_q;
  assign rd_block_y = tag_q[rdb_q];
  assign rd_last    = rd_valid && (bx_q == LAST_X) && (tag_q[rdb_q] == LAST_Y);

  always_comb begin
    bst_d  = bst_q;
    tag_d  = tag_q;
    line_d = line_q;
    row_d  = row_q;
    wrb_d  = wrb_q;
    rdb_d  = rdb_q;
    bx_d   = bx_q;
    ovf_d  = ovf_q;
    rs_d   = rs_q;

    // frame_start is resolved first so a coincident line_done becomes line 0 of the new frame
    if (frame_start) begin
      line_d = '0;
      row_d  = '0;
      for (int b = 0; b < 2; b++)
        if (bst_q[b] == B_FILLING) bst_d[b] = B_EMPTY;
    end

    if (line_done) begin
      if (wr_ready) begin
        if (line_d == 3'd0) begin
          bst_d[wrb_q] = B_FILLING;
          tag_d[wrb_q] = row_d;
        end
        if (line_d == 3'd7) begin
          bst_d[wrb_q] = B_FULL;
          wrb_d        = ~wrb_q;
          line_d       = '0;
          row_d        = (row_d == LAST_Y) ? '0 : row_d + BY_W'(1);
        end else begin
          line_d = line_d + 3'd1;
        end
      end else begin
        ovf_d = 1'b1;
      end
    end

    // Writer only ever touches an EMPTY/FILLING bank, reader only FULL/READING, so no overlap.
    case (rs_q)
      R_IDLE: if (bst_q[rdb_q] == B_FULL) begin
        bst_d[rdb_q] = B_READING;
        rs_d         = R_OFFER;
      end
      R_OFFER: if (rd_ready) rs_d = R_BUSY;
      R_BUSY: if (block_done) begin
        if (bx_q == LAST_X) begin
          bst_d[rdb_q] = B_EMPTY;
          bx_d         = '0;
          rdb_d        = ~rdb_q;
          rs_d         = R_IDLE;
        end else begin
          bx_d = bx_q + BX_W'(1);
          rs_d = R_OFFER;
        end
      end
      default: rs_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        bst_q[b] <= B_EMPTY;
        tag_q[b] <= '0;
      end
      line_q <= '0;
      row_q  <= '0;
      wrb_q  <= 1'b0;
      rdb_q  <= 1'b0;
      bx_q   <= '0;
      ovf_q  <= 1'b0;
      rs_q   <= R_IDLE;
    end else begin
      for (int b = 0; b < 2; b++) begin
        bst_q[b] <= bst_d[b];
        tag_q[b] <= tag_d[b];
      end
      line_q <= line_d;
      row_q  <= row_d;
      wrb_q  <= wrb_d;
      rdb_q  <= rdb_d;
      bx_q   <= bx_d;
      ovf_q  <= ovf_d;
      rs_q   <= rs_d;
    end
  end

`ifdef PINGPONG_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      if (line_done && !wr_ready && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (frame_start) frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// Directed bench for pingpong_bank_ctrl at WIDTH=64, HEIGHT=16 (8 block columns, 2 block rows).
module tb_pingpong_bank_ctrl;
  localparam int WIDTH = 64, HEIGHT = 16;
  localparam int BX_W = $clog2(WIDTH/8), BY_W = $clog2(HEIGHT/8);

  logic clk = 1'b0, rst_n = 1'b0;
  logic frame_start = 1'b0, line_done = 1'b0, rd_ready = 1'b0, block_done = 1'b0;
  logic wr_bank, wr_ready, overflow, rd_valid, rd_bank, rd_last;
  logic [BX_W-1:0] rd_block_x;
  logic [BY_W-1:0] rd_block_y;
`ifdef PINGPONG_STATS_EN
  logic [15:0] drop_cnt, frame_cnt;
`endif

  int ncmp = 0, nerr = 0;

  pingpong_bank_ctrl #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_done(line_done),
    .wr_bank(wr_bank), .wr_ready(wr_ready), .overflow(overflow), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .block_done(block_done), .rd_bank(rd_bank),
    .rd_block_x(rd_block_x), .rd_block_y(rd_block_y),
`ifdef PINGPONG_STATS_EN
    .drop_cnt(drop_cnt), .frame_cnt(frame_cnt),
`endif
    .rd_last(rd_last));

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; frame_start = 0; line_done = 0; rd_ready = 0; block_done = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      line_done = 1'b1; tick(); line_done = 1'b0;
    end
  endtask

  // Offer check, accept, then complete one block.
  task automatic one_block(input string tag, input int x, input int y, input logic last);
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_x"}, 32'(rd_block_x), 32'(x));
    chk({tag, "_y"}, 32'(rd_block_y), 32'(y));
    chk({tag, "_last"}, 32'(rd_last), 32'(last));
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk({tag, "_busy_valid"}, 32'(rd_valid), 32'd0);
    block_done = 1'b1; tick(); block_done = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_wr_bank", 32'(wr_bank), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_rd_x", 32'(rd_block_x), 32'd0);
    chk("rst_rd_last", 32'(rd_last), 32'd0);

    // Fill bank0 with rd_ready low; offer appears one cycle after FULL and holds
    lines(8);
    chk("fill_novalid_yet", 32'(rd_valid), 32'd0);
    tick();
    chk("offer_valid", 32'(rd_valid), 32'd1);
    chk("offer_bank", 32'(rd_bank), 32'd0);
    chk("offer_x", 32'(rd_block_x), 32'd0);
    chk("offer_y", 32'(rd_block_y), 32'd0);
    chk("offer_wr_bank", 32'(wr_bank), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_stable", {rd_valid, rd_bank, 4'(rd_block_x), 4'(rd_block_y), wr_bank},
          {1'b1, 1'b0, 4'd0, 4'd0, 1'b1});
    end

    // block_done while offering is ignored
    block_done = 1'b1; tick(); block_done = 1'b0;
    chk("ign_done_x", 32'(rd_block_x), 32'd0);
    chk("ign_done_valid", 32'(rd_valid), 32'd1);

    // Drain bank0, then fill and drain bank1 (row 1)
    for (int x = 0; x < 8; x++) one_block("b0", x, 0, 1'b0);
    chk("rel0_valid", 32'(rd_valid), 32'd0);
    chk("rel0_rd_bank", 32'(rd_bank), 32'd1);
    lines(8);
    tick();
    chk("b1_offer_bank", 32'(rd_bank), 32'd1);
    for (int x = 0; x < 8; x++) one_block("b1", x, 1, x == 7);
    chk("rel1_rd_bank", 32'(rd_bank), 32'd0);
    chk("rel1_wr_bank", 32'(wr_bank), 32'd0);

    // Overflow: both banks held, 17th line dropped
    do_reset();
    lines(16);
    chk("ovf_wr_ready", 32'(wr_ready), 32'd0);
    chk("ovf_pre", 32'(overflow), 32'd0);
    lines(1);
    chk("ovf_set", 32'(overflow), 32'd1);
    for (int x = 0; x < 8; x++) one_block("ovf_b0", x, 0, 1'b0);
    chk("ovf_drain_ready", 32'(wr_ready), 32'd1);
    chk("ovf_drain_wrbank", 32'(wr_bank), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    tick();
    chk("ovf_b1_valid", 32'(rd_valid), 32'd1);
    chk("ovf_b1_y", 32'(rd_block_y), 32'd1);
`ifdef PINGPONG_STATS_EN
    chk("stat_drop", 32'(drop_cnt), 32'd1);
`endif

    // frame_start discards a partial bank
    do_reset();
    lines(3);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    lines(5);
    tick();
    chk("fs_partial_novalid", 32'(rd_valid), 32'd0);
    lines(3);
    tick();
    chk("fs_offer_valid", 32'(rd_valid), 32'd1);
    chk("fs_offer_bank", 32'(rd_bank), 32'd0);
    chk("fs_offer_y", 32'(rd_block_y), 32'd0);
    chk("fs_wr_bank", 32'(wr_bank), 32'd1);
`ifdef PINGPONG_STATS_EN
    chk("stat_frames", 32'(frame_cnt), 32'd1);
`endif

    // Release of bank0 coincides with completion of bank1's fill
    do_reset();
    lines(8);
    tick();
    lines(7);
    for (int x = 0; x < 7; x++) one_block("sc_b0", x, 0, 1'b0);
    chk("sc_last_x", 32'(rd_block_x), 32'd7);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    line_done = 1'b1; block_done = 1'b1; tick(); line_done = 1'b0; block_done = 1'b0;
    chk("sc_wr_bank", 32'(wr_bank), 32'd0);
    chk("sc_wr_ready", 32'(wr_ready), 32'd1);
    chk("sc_overflow", 32'(overflow), 32'd0);
    chk("sc_valid_gap", 32'(rd_valid), 32'd0);
    tick();
    chk("sc_valid", 32'(rd_valid), 32'd1);
    chk("sc_rd_bank", 32'(rd_bank), 32'd1);
    chk("sc_rd_y", 32'(rd_block_y), 32'd1);

    // Asynchronous reset mid-offer
    #2 rst_n = 1'b0; #1;
    chk("async_rst_valid", 32'(rd_valid), 32'd0);
    chk("async_rst_bank", 32'(rd_bank), 32'd0);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
